// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: register file with write-back bypass, control decode,
// sign extension, load-use hazard detection and an ID/EX register with valid bit.
module decode_stage_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned ALUOP_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [31:0]        instruccion,
  input  logic               flush,
  input  logic               wb_we,
  input  logic [4:0]         wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               stall,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_data1,
  output logic [DATA_W-1:0]  ex_data2,
  output logic [DATA_W-1:0]  ex_ext_sig,
  output logic [4:0]         ex_rs,
  output logic [4:0]         ex_rt,
  output logic [4:0]         ex_rd,
  output logic               ex_branch,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_reg_dst,
  output logic               ex_reg_write,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;

  // Control bundle order: {branch, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src}
  localparam int unsigned CtlW = 7;

  logic [DATA_W-1:0] regs_q [NREGS];

  logic [5:0]         opcode;
  logic [AW-1:0]      rs_idx, rt_idx, wb_idx;
  logic [DATA_W-1:0]  rd1, rd2, ext_sig;
  logic [CtlW-1:0]    ctl;
  logic [ALUOP_W-1:0] alu_op;
  logic               issue;

  logic               ex_valid_q;
  logic [CtlW-1:0]    ex_ctl_q;
  logic [ALUOP_W-1:0] ex_alu_op_q;
  logic [DATA_W-1:0]  ex_data1_q, ex_data2_q, ex_ext_sig_q;
  logic [4:0]         ex_rs_q, ex_rt_q, ex_rd_q;

  assign opcode = instruccion[31:26];
  assign rs_idx = instruccion[21 +: AW];
  assign rt_idx = instruccion[16 +: AW];
  assign wb_idx = wb_addr[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_we && wb_idx != '0) begin
      regs_q[wb_idx] <= wb_data;
    end
  end

  // Same-cycle write-back is forwarded so decode never sees a stale value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs_idx != '0) rd1 = (wb_we && wb_idx == rs_idx) ? wb_data : regs_q[rs_idx];
    if (rt_idx != '0) rd2 = (wb_we && wb_idx == rt_idx) ? wb_data : regs_q[rt_idx];
  end

  always_comb begin
    ctl = '0;
    unique case (opcode)
      OpRtype: ctl = 7'b0000110;
      OpLw:    ctl = 7'b0101011;
      OpSw:    ctl = 7'b0010001;
      OpBeq:   ctl = 7'b1000000;
      OpAddi:  ctl = 7'b0000011;
      default: ctl = '0;
    endcase
  end

  assign alu_op  = ALUOP_W'(opcode);
  assign ext_sig = DATA_W'($signed(instruccion[15:0]));

  // Conservative: rt is compared even for opcodes that do not read it.
  always_comb begin
    stall = 1'b0;
    if (!rst && !flush && instr_valid && ex_valid_q && ex_ctl_q[5] && ex_rt_q != 5'd0 &&
        (ex_rt_q == instruccion[25:21] || ex_rt_q == instruccion[20:16])) begin
      stall = 1'b1;
    end
  end

  assign issue = instr_valid && !flush && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_ctl_q     <= '0;
      ex_alu_op_q  <= '0;
      ex_data1_q   <= '0;
      ex_data2_q   <= '0;
      ex_ext_sig_q <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
    end else begin
      ex_valid_q   <= issue;
      ex_ctl_q     <= issue ? ctl : '0;
      ex_alu_op_q  <= issue ? alu_op : '0;
      ex_data1_q   <= rd1;
      ex_data2_q   <= rd2;
      ex_ext_sig_q <= ext_sig;
      ex_rs_q      <= instruccion[25:21];
      ex_rt_q      <= instruccion[20:16];
      ex_rd_q      <= instruccion[15:11];
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_data1      = ex_data1_q;
  assign ex_data2      = ex_data2_q;
  assign ex_ext_sig    = ex_ext_sig_q;
  assign ex_rs         = ex_rs_q;
  assign ex_rt         = ex_rt_q;
  assign ex_rd         = ex_rd_q;
  assign ex_branch     = ex_ctl_q[6];
  assign ex_mem_read   = ex_ctl_q[5];
  assign ex_mem_write  = ex_ctl_q[4];
  assign ex_mem_to_reg = ex_ctl_q[3];
  assign ex_reg_dst    = ex_ctl_q[2];
  assign ex_reg_write  = ex_ctl_q[1];
  assign ex_alu_src    = ex_ctl_q[0];
  assign ex_alu_op     = ex_alu_op_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed self-checking bench for decode_stage_pipe: regfile, bypass, control,
// load-use stall, flush and asynchronous reset.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instruccion;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall, ex_valid;
  logic [31:0] ex_data1, ex_data2, ex_ext_sig;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_reg_dst, ex_reg_write, ex_alu_src;
  logic [5:0]  ex_alu_op;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decode_stage_pipe #(.DATA_W(32), .NREGS(32), .ALUOP_W(6)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruccion(instruccion),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_data1(ex_data1), .ex_data2(ex_data2),
    .ex_ext_sig(ex_ext_sig), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_dst(ex_reg_dst), .ex_reg_write(ex_reg_write),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b1; instruccion = rtype(5'd1, 5'd2, 5'd3); flush = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    #3;
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ex_valid); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else n_pass++;
    n_checks++; if (ex_data1 !== 32'h0) $display("FAIL reset_data1 got %h want 0", ex_data1); else n_pass++;
    n_checks++; if (ex_reg_write !== 1'b0) $display("FAIL reset_regwr got %b want 0", ex_reg_write); else n_pass++;
    @(negedge clk);
    rst = 1'b0; instr_valid = 1'b0;
  endtask

  task automatic test_rtype();
    for (int i = 1; i < 32; i++) begin
      wb_we = 1'b1; wb_addr = 5'(i); wb_data = 32'(i * 3);
      tick();
    end
    wb_we = 1'b0;
    instr_valid = 1'b1; instruccion = rtype(5'd5, 5'd6, 5'd7);
    tick();
    n_checks++; if (ex_data1 !== 32'd15) $display("FAIL rt_data1 got %0d want 15", ex_data1); else n_pass++;
    n_checks++; if (ex_data2 !== 32'd18) $display("FAIL rt_data2 got %0d want 18", ex_data2); else n_pass++;
    n_checks++; if (ex_rd !== 5'd7) $display("FAIL rt_rd got %0d want 7", ex_rd); else n_pass++;
    n_checks++; if (ex_reg_write !== 1'b1) $display("FAIL rt_regwr got %b want 1", ex_reg_write); else n_pass++;
    n_checks++; if (ex_reg_dst !== 1'b1) $display("FAIL rt_regdst got %b want 1", ex_reg_dst); else n_pass++;
    n_checks++; if (ex_valid !== 1'b1) $display("FAIL rt_valid got %b want 1", ex_valid); else n_pass++;
    n_checks++; if (ex_mem_read !== 1'b0) $display("FAIL rt_memrd got %b want 0", ex_mem_read); else n_pass++;
  endtask

  task automatic test_bypass();
    instruccion = rtype(5'd4, 5'd0, 5'd1);
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'hDEAD0001;
    tick();
    n_checks++; if (ex_data1 !== 32'hDEAD0001) $display("FAIL byp_data1 got %h want dead0001", ex_data1); else n_pass++;
    n_checks++; if (ex_data2 !== 32'h0) $display("FAIL byp_r0 got %h want 0", ex_data2); else n_pass++;
    instruccion = rtype(5'd0, 5'd4, 5'd2);
    wb_addr = 5'd0; wb_data = 32'h55;
    tick();
    n_checks++; if (ex_data1 !== 32'h0) $display("FAIL byp_r0wb got %h want 0", ex_data1); else n_pass++;
    n_checks++; if (ex_data2 !== 32'hDEAD0001) $display("FAIL byp_written got %h want dead0001", ex_data2); else n_pass++;
    wb_we = 1'b0;
  endtask

  task automatic test_control();
    instruccion = itype(6'h2B, 5'd1, 5'd2, 16'h0010);
    tick();
    n_checks++; if (ex_mem_write !== 1'b1) $display("FAIL sw_memwr got %b want 1", ex_mem_write); else n_pass++;
    n_checks++; if (ex_reg_write !== 1'b0) $display("FAIL sw_regwr got %b want 0", ex_reg_write); else n_pass++;
    n_checks++; if (ex_alu_src !== 1'b1) $display("FAIL sw_alusrc got %b want 1", ex_alu_src); else n_pass++;
    instruccion = itype(6'h04, 5'd1, 5'd2, 16'h0003);
    tick();
    n_checks++; if (ex_branch !== 1'b1) $display("FAIL beq_branch got %b want 1", ex_branch); else n_pass++;
    instruccion = itype(6'h08, 5'd1, 5'd2, 16'h0003);
    tick();
    n_checks++; if ({ex_alu_src, ex_reg_write, ex_reg_dst} !== 3'b110) $display("FAIL addi_ctl got %b want 110", {ex_alu_src, ex_reg_write, ex_reg_dst}); else n_pass++;
    instruccion = itype(6'h3F, 5'd1, 5'd2, 16'h0003);
    tick();
    n_checks++; if ({ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_dst, ex_reg_write, ex_alu_src} !== 7'b0) $display("FAIL unk_ctl got nonzero want 0"); else n_pass++;
    n_checks++; if (ex_alu_op !== 6'h3F) $display("FAIL unk_aluop got %h want 3f", ex_alu_op); else n_pass++;
    instr_valid = 1'b0;
    tick();
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL invalid_bubble got %b want 0", ex_valid); else n_pass++;
    instr_valid = 1'b1;
  endtask

  task automatic test_load_use();
    instruccion = itype(6'h23, 5'd1, 5'd8, 16'h0004);
    tick();
    n_checks++; if (ex_mem_read !== 1'b1) $display("FAIL lu_lw_memrd got %b want 1", ex_mem_read); else n_pass++;
    instruccion = rtype(5'd8, 5'd2, 5'd3);
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL lu_stall got %b want 1", stall); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble_valid got %b want 0", ex_valid); else n_pass++;
    n_checks++; if (ex_reg_write !== 1'b0) $display("FAIL lu_bubble_regwr got %b want 0", ex_reg_write); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_stall_len got %b want 0", stall); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b1) $display("FAIL lu_issue_valid got %b want 1", ex_valid); else n_pass++;
    n_checks++; if (ex_rs !== 5'd8) $display("FAIL lu_issue_rs got %0d want 8", ex_rs); else n_pass++;
    n_checks++; if (ex_data1 !== 32'd24) $display("FAIL lu_issue_data1 got %0d want 24", ex_data1); else n_pass++;
  endtask

  task automatic test_no_false_stall();
    instruccion = itype(6'h23, 5'd1, 5'd0, 16'h0000);
    tick();
    instruccion = rtype(5'd0, 5'd0, 5'd5);
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL nfs_r0 got %b want 0", stall); else n_pass++;
    tick();
    instruccion = itype(6'h23, 5'd1, 5'd9, 16'h0000);
    tick();
    instruccion = rtype(5'd10, 5'd11, 5'd12);
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL nfs_other got %b want 0", stall); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b1) $display("FAIL nfs_issue got %b want 1", ex_valid); else n_pass++;
  endtask

  task automatic test_flush();
    instruccion = itype(6'h23, 5'd1, 5'd8, 16'h0000);
    tick();
    instruccion = rtype(5'd8, 5'd0, 5'd1);
    flush = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL fl_stall got %b want 0", stall); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL fl_valid got %b want 0", ex_valid); else n_pass++;
    flush = 1'b0;
    instruccion = itype(6'h23, 5'd2, 5'd3, 16'hFFFC);
    tick();
    n_checks++; if (ex_ext_sig !== 32'hFFFFFFFC) $display("FAIL fl_ext got %h want fffffffc", ex_ext_sig); else n_pass++;
    n_checks++; if (ex_mem_read !== 1'b1) $display("FAIL fl_memrd got %b want 1", ex_mem_read); else n_pass++;
    n_checks++; if (ex_alu_op !== 6'h23) $display("FAIL fl_aluop got %h want 23", ex_alu_op); else n_pass++;
    n_checks++; if (ex_mem_to_reg !== 1'b1) $display("FAIL fl_memtoreg got %b want 1", ex_mem_to_reg); else n_pass++;
  endtask

  task automatic test_async_reset();
    instruccion = rtype(5'd3, 5'd0, 5'd1);
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL ar_prestall got %b want 1", stall); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL ar_stall got %b want 0", stall); else n_pass++;
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL ar_valid got %b want 0", ex_valid); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    instruccion = rtype(5'd5, 5'd6, 5'd7);
    tick();
    n_checks++; if (ex_data1 !== 32'h0) $display("FAIL ar_reg5 got %h want 0", ex_data1); else n_pass++;
    n_checks++; if (ex_data2 !== 32'h0) $display("FAIL ar_reg6 got %h want 0", ex_data2); else n_pass++;
    n_checks++; if (ex_valid !== 1'b1) $display("FAIL ar_issue got %b want 1", ex_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_bypass();
    test_control();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
